// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master scheduler slice.
package spi_pkg;

   localparam int unsigned SPI_WORD_BITS = 8;
   localparam int unsigned SEL_W         = 2;

   localparam logic [SEL_W-1:0] SPI_DESELECT = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      START = 3'd2,
      XFER  = 3'd3,
      DONE  = 3'd4,
      GAP   = 3'd5
   } sched_state_e;

   // One requester's transfer as captured at arbitration time.
   typedef struct packed {
      logic [SEL_W-1:0]         slave;
      logic [SPI_WORD_BITS-1:0] data;
   } spi_req_t;

endpackage

// File: rtl/spi_master_scheduler_if.sv
// Client-side request/ack bus plus the SPI master control bus of the scheduler.
interface spi_master_scheduler_if
   import spi_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
);

   logic [NUM_REQ-1:0]               req;
   logic [SEL_W*NUM_REQ-1:0]         req_slave;
   logic [SPI_WORD_BITS*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]               ack;
   logic [SPI_WORD_BITS-1:0]         rx_data;
   logic                             err;
   logic                             busy;
   logic                             spi_start;
   logic [SEL_W-1:0]                 spi_slave_select;
   logic [SPI_WORD_BITS-1:0]         spi_data_to_send;
   logic [SPI_WORD_BITS-1:0]         spi_data_received;

   // The scheduler itself.
   modport slave (
      input  req, req_slave, req_data, spi_data_received,
      output ack, rx_data, err, busy, spi_start, spi_slave_select, spi_data_to_send
   );

   // Clients plus the SPI master, seen from outside the scheduler.
   modport master (
      output req, req_slave, req_data, spi_data_received,
      input  ack, rx_data, err, busy, spi_start, spi_slave_select, spi_data_to_send
   );

endinterface

// File: rtl/spi_master_scheduler_rr_arbiter.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module rr_arbiter
   import spi_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner_c,
   output logic               valid_c
);

   int unsigned idx;

   // Scan from the farthest offset down so the nearest hit to ptr wins.
   always_comb begin
      winner_c = '0;
      valid_c  = 1'b0;
      idx      = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr) + NUM_REQ - 1 - k) % NUM_REQ;
         if (req[idx[IDX_W-1:0]]) begin
            winner_c = IDX_W'(idx);
            valid_c  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_master_scheduler.sv
// Shares one SPI master among NUM_REQ clients: arbitrates, sequences and times each byte exchange.
module spi_master_scheduler
   import spi_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 3,
   parameter int unsigned XFER_CYCLES = 10,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input logic                   clk,
   input logic                   reset,
   spi_master_scheduler_if.slave bus
);

   localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   sched_state_e     state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] win_idx;
   logic [CNT_W-1:0] counter;
   spi_req_t         cur;

   logic [IDX_W-1:0] grant_c;
   logic             grant_valid_c;
   spi_req_t         pick_c;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req      (bus.req),
      .ptr      (rr_ptr),
      .winner_c (grant_c),
      .valid_c  (grant_valid_c)
   );

   // Slave index and byte belonging to the current arbitration winner.
   always_comb begin
      pick_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_c == IDX_W'(i)) begin
            pick_c.slave = bus.req_slave[SEL_W*i +: SEL_W];
            pick_c.data  = bus.req_data[SPI_WORD_BITS*i +: SPI_WORD_BITS];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                <= IDLE;
         rr_ptr               <= '0;
         win_idx              <= '0;
         counter              <= '0;
         cur                  <= '0;
         bus.ack              <= '0;
         bus.err              <= 1'b0;
         bus.busy             <= 1'b0;
         bus.rx_data          <= '0;
         bus.spi_start        <= 1'b0;
         bus.spi_slave_select <= SPI_DESELECT;
         bus.spi_data_to_send <= '0;
      end else begin
         bus.ack <= '0;
         bus.err <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid_c) begin
                  win_idx  <= grant_c;
                  cur      <= pick_c;
                  bus.busy <= 1'b1;
                  // An illegal slave index is answered without touching the bus.
                  state    <= (pick_c.slave == SPI_DESELECT) ? DONE : SETUP;
               end
            end
            SETUP: begin
               bus.spi_data_to_send <= cur.data;
               state                <= START;
            end
            START: begin
               bus.spi_start        <= 1'b1;
               bus.spi_slave_select <= cur.slave;
               counter              <= '0;
               state                <= XFER;
            end
            XFER: begin
               bus.spi_start <= 1'b0;
               if (counter == CNT_W'(XFER_CYCLES - 1)) begin
                  bus.rx_data <= bus.spi_data_received;
                  state       <= DONE;
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end
            DONE: begin
               bus.ack              <= NUM_REQ'(1) << win_idx;
               bus.err              <= (cur.slave == SPI_DESELECT);
               bus.spi_slave_select <= SPI_DESELECT;
               rr_ptr               <= (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
               counter              <= '0;
               if (cur.slave == SPI_DESELECT) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  state <= GAP;
               end
            end
            GAP: begin
               if (counter == CNT_W'(GAP_CYCLES - 1)) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_scheduler.sv
// Scoreboard bench: stimulus queues expected acks/SPI starts, monitors pop and compare.
module tb_spi_master_scheduler;
   import spi_pkg::*;

   localparam int unsigned NUM_REQ     = 3;
   localparam int unsigned XFER_CYCLES = 10;
   localparam int unsigned GAP_CYCLES  = 2;
   // Drive negedge to ack-visible negedge, and ack-to-ack spacing for back-to-back work.
   localparam int unsigned LAT     = 14;
   localparam int unsigned SPACING = 16;

   typedef struct {
      int unsigned idx;
      logic [7:0]  rx;
      logic        err;
      int unsigned due;
   } exp_t;

   typedef struct {
      logic [1:0] slave;
      logic [7:0] tx;
      logic [7:0] rx;
   } spi_exp_t;

   exp_t        exp_q[$];
   spi_exp_t    spi_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int unsigned hold[NUM_REQ];
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  spi_rx = 8'h00;
   logic        prev_start = 1'b0;

   spi_master_scheduler_if #(.NUM_REQ(NUM_REQ)) bus_if ();

   assign bus_if.spi_data_received = spi_rx;

   spi_master_scheduler #(
      .NUM_REQ     (NUM_REQ),
      .XFER_CYCLES (XFER_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Ack monitor.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus_if.ack != '0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'(bus_if.ack), 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("ack_vec", 32'(bus_if.ack), 32'(1) << e.idx);
            check("ack_rx", 32'(bus_if.rx_data), 32'(e.rx));
            check("ack_err", 32'(bus_if.err), 32'(e.err));
            check("ack_cycle", cyc, e.due);
         end
      end
   end

   // SPI master model: checks each start and supplies the byte it will "receive".
   always @(negedge clk) begin
      spi_exp_t s;
      if (!reset && bus_if.spi_start) begin
         check("start_one_cycle", 32'(prev_start), 32'h0);
         if (spi_q.size() == 0) begin
            check("unexpected_start", 32'(bus_if.spi_start), 32'h0);
         end else begin
            s = spi_q.pop_front();
            check("start_select", 32'(bus_if.spi_slave_select), 32'(s.slave));
            check("start_tx", 32'(bus_if.spi_data_to_send), 32'(s.tx));
            spi_rx = s.rx;
         end
      end
      prev_start = bus_if.spi_start;
   end

   // Every stimulus wait goes through here; clients drop req on their ack unless told to hold.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (bus_if.ack[i]) begin
            if (hold[i] > 0) hold[i]--;
            else bus_if.req[i] = 1'b0;
         end
      end
   endtask

   task automatic post(input int unsigned i, input logic [1:0] slave, input logic [7:0] data,
                       input int unsigned hold_n);
      bus_if.req_slave[2*i +: 2] = slave;
      bus_if.req_data[8*i +: 8]  = data;
      hold[i]                    = hold_n;
      bus_if.req[i]              = 1'b1;
   endtask

   task automatic expect_xfer(input int unsigned i, input logic [1:0] slave, input logic [7:0] tx,
                              input logic [7:0] rx, input int unsigned due);
      spi_q.push_back('{slave: slave, tx: tx, rx: rx});
      exp_q.push_back('{idx: i, rx: rx, err: 1'b0, due: due});
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      while ((bus_if.busy || bus_if.req != '0 || exp_q.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      check("idle_timeout", 32'(n < 300), 32'h1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"}, 32'(bus_if.ack), 32'h0);
      check({tag, "_err"}, 32'(bus_if.err), 32'h0);
      check({tag, "_busy"}, 32'(bus_if.busy), 32'h0);
      check({tag, "_start"}, 32'(bus_if.spi_start), 32'h0);
      check({tag, "_select"}, 32'(bus_if.spi_slave_select), 32'h3);
      check({tag, "_tx"}, 32'(bus_if.spi_data_to_send), 32'h0);
      check({tag, "_rx"}, 32'(bus_if.rx_data), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int unsigned p;
      for (int i = 0; i < int'(NUM_REQ); i++) hold[i] = 0;
      bus_if.req       = '0;
      bus_if.req_slave = '0;
      bus_if.req_data  = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b0;
      tick();

      // All three at once from rr_ptr 0: served 0, 1, 2.
      p = cyc;
      post(0, 2'd1, 8'h10, 0);
      post(1, 2'd2, 8'h21, 0);
      post(2, 2'd0, 8'h32, 0);
      expect_xfer(0, 2'd1, 8'h10, 8'hA0, p + LAT);
      expect_xfer(1, 2'd2, 8'h21, 8'hB1, p + LAT + SPACING);
      expect_xfer(2, 2'd0, 8'h32, 8'hC2, p + LAT + 2*SPACING);
      wait_idle();

      // Fairness: req0 and req2 each re-request once after their ack -> 0, 2, 0, 2.
      p = cyc;
      post(0, 2'd1, 8'h5A, 1);
      post(2, 2'd2, 8'hC3, 1);
      expect_xfer(0, 2'd1, 8'h5A, 8'hE1, p + LAT);
      expect_xfer(2, 2'd2, 8'hC3, 8'h1E, p + LAT + SPACING);
      expect_xfer(0, 2'd1, 8'h5A, 8'hE2, p + LAT + 2*SPACING);
      expect_xfer(2, 2'd2, 8'hC3, 8'h2E, p + LAT + 3*SPACING);
      wait_idle();

      // Single request with start timing checked directly.
      p = cyc;
      post(0, 2'd1, 8'hA5, 0);
      expect_xfer(0, 2'd1, 8'hA5, 8'h3C, p + LAT);
      repeat (2) tick();
      check("setup_start", 32'(bus_if.spi_start), 32'h0);
      check("setup_select", 32'(bus_if.spi_slave_select), 32'h3);
      check("setup_tx", 32'(bus_if.spi_data_to_send), 32'hA5);
      tick();
      check("start_high", 32'(bus_if.spi_start), 32'h1);
      check("start_sel", 32'(bus_if.spi_slave_select), 32'h1);
      wait_idle();

      // Illegal slave 3: err ack one cycle after sampling, rx_data held, no SPI start.
      p = cyc;
      post(1, 2'd3, 8'h55, 0);
      exp_q.push_back('{idx: 1, rx: 8'h3C, err: 1'b1, due: p + 2});
      tick();
      check("err_busy", 32'(bus_if.busy), 32'h1);
      check("err_select", 32'(bus_if.spi_slave_select), 32'h3);
      wait_idle();

      // Inputs changed mid-transfer do not disturb the latched byte or slave.
      p = cyc;
      post(2, 2'd2, 8'h96, 0);
      expect_xfer(2, 2'd2, 8'h96, 8'h69, p + LAT);
      repeat (6) tick();
      bus_if.req_data[16 +: 8]  = 8'hFF;
      bus_if.req_slave[4 +: 2] = 2'd0;
      repeat (2) tick();
      check("stable_tx", 32'(bus_if.spi_data_to_send), 32'h96);
      check("stable_sel", 32'(bus_if.spi_slave_select), 32'h2);
      wait_idle();

      // Reset asserted mid-XFER: everything returns to reset values at once, no ack.
      p = cyc;
      post(1, 2'd0, 8'h11, 0);
      spi_q.push_back('{slave: 2'd0, tx: 8'h11, rx: 8'h77});
      repeat (8) tick();
      check("pre_reset_busy", 32'(bus_if.busy), 32'h1);
      #2 reset = 1'b1;
      bus_if.req = '0;
      #1 check_reset_outputs("mid");
      @(negedge clk);
      reset = 1'b0;
      tick();

      // After reset rr_ptr is 0; lone req1 still wins and completes normally.
      p = cyc;
      post(1, 2'd0, 8'h22, 0);
      expect_xfer(1, 2'd0, 8'h22, 8'hC3, p + LAT);
      wait_idle();

      repeat (4) tick();
      check("ack_queue_empty", 32'(exp_q.size()), 32'h0);
      check("spi_queue_empty", 32'(spi_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
